// File: rtl/evu_event_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// evu_event_arbiter_pkg
//   Shared types and constants for the EVU -> SPU event arbiter.
//   - EVU_NUM_LINES / EVU_INFO_W : line count and info width shared with evu_top
//   - evu_arb_rec_t              : one drained event record (default widths)
//   - evu_arb_state_e            : arbiter output FSM states
// ---------------------------------------------------------------------------
package evu_event_arbiter_pkg;

    localparam int EVU_NUM_LINES = 4;
    localparam int EVU_INFO_W    = 18;  // {priv[1:0], asid[15:0]}
    localparam int EVU_CNT_W     = 8;
    localparam int EVU_LINE_W    = (EVU_NUM_LINES > 1) ? $clog2(EVU_NUM_LINES) : 1;

    typedef struct packed {
        logic [EVU_LINE_W-1:0] line;
        logic [EVU_CNT_W-1:0]  count;
        logic                  ovf;
        logic [EVU_INFO_W-1:0] info;
    } evu_arb_rec_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_VALID = 1'b1
    } evu_arb_state_e;

endpackage

// File: rtl/evu_rr_arbiter.sv
// ---------------------------------------------------------------------------
// evu_rr_arbiter
//   Round-robin grant: first requester searching upward from rr+1 (modulo N).
//   The rr pointer moves to the granted index when advance_i is strobed.
//   Ports:
//     clk_i, rst_ni : clock, async active-low reset
//     req_i         : request vector
//     advance_i     : the current grant is consumed this cycle
//     gnt_o         : one-hot grant
//     idx_o         : index of the grant
//     any_o         : at least one request present
// ---------------------------------------------------------------------------
module evu_rr_arbiter #(
    parameter int N      = 4,
    parameter int LINE_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N-1:0]      req_i,
    input  logic              advance_i,
    output logic [N-1:0]      gnt_o,
    output logic [LINE_W-1:0] idx_o,
    output logic              any_o
);

    logic [LINE_W-1:0] rr_q, rr_d;

    always_comb begin
        logic found;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        // i runs 1..N so the last-granted line is searched last.
        for (int i = 1; i <= N; i++) begin
            if (!found && req_i[(int'(rr_q) + i) % N]) begin
                found                          = 1'b1;
                gnt_o[(int'(rr_q) + i) % N]    = 1'b1;
                idx_o                          = LINE_W'((int'(rr_q) + i) % N);
            end
        end
    end

    assign any_o = |req_i;
    assign rr_d  = advance_i ? idx_o : rr_q;

    // NOTE: sequential state uses non-blocking assignments only; all next-state
    // values come from always_comb, so no ordering hazards between flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= LINE_W'(N - 1);  // line 0 wins the first arbitration
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/evu_event_arbiter.sv
// ---------------------------------------------------------------------------
// evu_event_arbiter
//   Accumulates EVU event pulses in per-line saturating counters and drains
//   them, round-robin, one record at a time to the SPU over valid/ready.
//   Optional macro EVU_ARB_TIMESTAMP_EN adds a free-running timestamp that is
//   sampled into out_ts_o at capture.
//   Ports:
//     clk_i, rst_ni  : clock, async active-low reset
//     enable_i       : global enable; low clears all pending state
//     line_en_i      : per-line enable mask (masks new events only)
//     evt_i          : one event pulse per line per cycle
//     evt_info_i     : {priv, asid} qualifying this cycle's events
//     out_valid_o / out_ready_i : record handshake
//     out_line_o, out_count_o, out_ovf_o, out_info_o : record fields
//     out_ts_o       : capture timestamp (macro only)
//     busy_o         : pending events or a record in flight
// ---------------------------------------------------------------------------
module evu_event_arbiter
    import evu_event_arbiter_pkg::*;
#(
    parameter  int NUM_LINES = EVU_NUM_LINES,
    parameter  int CNT_W     = EVU_CNT_W,
    parameter  int INFO_W    = EVU_INFO_W,
`ifdef EVU_ARB_TIMESTAMP_EN
    parameter  int TS_W      = 32,
`endif
    localparam int LINE_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic [NUM_LINES-1:0] line_en_i,
    input  logic [NUM_LINES-1:0] evt_i,
    input  logic [INFO_W-1:0]    evt_info_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [LINE_W-1:0]    out_line_o,
    output logic [CNT_W-1:0]     out_count_o,
    output logic                 out_ovf_o,
    output logic [INFO_W-1:0]    out_info_o,
`ifdef EVU_ARB_TIMESTAMP_EN
    output logic [TS_W-1:0]      out_ts_o,
`endif
    output logic                 busy_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]  cnt_q  [NUM_LINES];
    logic [CNT_W-1:0]  cnt_d  [NUM_LINES];
    logic [INFO_W-1:0] info_q [NUM_LINES];
    logic [INFO_W-1:0] info_d [NUM_LINES];
    logic [NUM_LINES-1:0] ovf_q, ovf_d;

    evu_arb_state_e state_q, state_d;

    logic [LINE_W-1:0] out_line_q,  out_line_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic              out_ovf_q,   out_ovf_d;
    logic [INFO_W-1:0] out_info_q,  out_info_d;

    logic [NUM_LINES-1:0] qual, pend, gnt;
    logic [LINE_W-1:0]    gnt_idx;
    logic                 any_pend, capture;

    assign qual = evt_i & line_en_i & {NUM_LINES{enable_i}};

    // Arbitration sees registered counters only, so a same-cycle event is not
    // visible until the following cycle.
    always_comb begin
        pend = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            pend[k] = (cnt_q[k] != '0);
        end
    end

    evu_rr_arbiter #(
        .N      (NUM_LINES),
        .LINE_W (LINE_W)
    ) u_rr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (pend),
        .advance_i (capture),
        .gnt_o     (gnt),
        .idx_o     (gnt_idx),
        .any_o     (any_pend)
    );

    // Output FSM. A handshake with more work pending recaptures in the same
    // cycle, giving back-to-back records with no bubble.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (enable_i && any_pend) begin
                    capture = 1'b1;
                    state_d = ARB_VALID;
                end
            end
            ARB_VALID: begin
                if (out_ready_i) begin
                    if (enable_i && any_pend) begin
                        capture = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Per-line counters. A captured line restarts at 1 if it also has an event
    // this cycle, so nothing arriving during capture is dropped.
    always_comb begin
        for (int k = 0; k < NUM_LINES; k++) begin
            cnt_d[k]  = cnt_q[k];
            ovf_d[k]  = ovf_q[k];
            info_d[k] = info_q[k];
            if (!enable_i) begin
                cnt_d[k]  = '0;
                ovf_d[k]  = 1'b0;
                info_d[k] = '0;
            end else begin
                if (qual[k]) begin
                    info_d[k] = evt_info_i;
                end
                if (capture && gnt[k]) begin
                    cnt_d[k] = qual[k] ? CNT_W'(1) : '0;
                    ovf_d[k] = 1'b0;
                end else if (qual[k]) begin
                    if (cnt_q[k] == CNT_MAX) begin
                        ovf_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        out_line_d  = out_line_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        out_info_d  = out_info_q;
        if (capture) begin
            out_line_d  = gnt_idx;
            out_count_d = cnt_q[gnt_idx];
            out_ovf_d   = ovf_q[gnt_idx];
            out_info_d  = info_q[gnt_idx];
        end
    end

    // NOTE: the counter/info arrays are real pending state that busy_o and the
    // arbiter read, so they are reset like any other flop, not left as RAM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_LINES; k++) begin
                cnt_q[k]  <= '0;
                info_q[k] <= '0;
            end
            ovf_q       <= '0;
            state_q     <= ARB_IDLE;
            out_line_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
            out_info_q  <= '0;
        end else begin
            for (int k = 0; k < NUM_LINES; k++) begin
                cnt_q[k]  <= cnt_d[k];
                info_q[k] <= info_d[k];
            end
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            out_line_q  <= out_line_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
            out_info_q  <= out_info_d;
        end
    end

`ifdef EVU_ARB_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d, out_ts_q, out_ts_d;

    assign ts_d     = ts_q + 1'b1;  // wraps to 0 after all-ones
    assign out_ts_d = capture ? ts_q : out_ts_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q     <= '0;
            out_ts_q <= '0;
        end else begin
            ts_q     <= ts_d;
            out_ts_q <= out_ts_d;
        end
    end

    assign out_ts_o = out_ts_q;
`endif

    assign out_valid_o = (state_q == ARB_VALID);
    assign out_line_o  = out_line_q;
    assign out_count_o = out_count_q;
    assign out_ovf_o   = out_ovf_q;
    assign out_info_o  = out_info_q;
    assign busy_o      = any_pend | out_valid_o;

endmodule

// File: tb/tb_evu_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_evu_event_arbiter
//   Directed bench for evu_event_arbiter: a vector table for single-cycle
//   behaviour plus hand-written sequences for saturation, fairness, flush and
//   (with EVU_ARB_TIMESTAMP_EN) the capture timestamp.
// ---------------------------------------------------------------------------
module tb_evu_event_arbiter;
    import evu_event_arbiter_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        enable_i;
    logic [3:0]  line_en_i;
    logic [3:0]  evt_i;
    logic [17:0] evt_info_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [1:0]  out_line_o;
    logic [7:0]  out_count_o;
    logic        out_ovf_o;
    logic [17:0] out_info_o;
    logic        busy_o;
`ifdef EVU_ARB_TIMESTAMP_EN
    logic [31:0] out_ts_o;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_i = ~clk_i;

    evu_event_arbiter dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .enable_i    (enable_i),
        .line_en_i   (line_en_i),
        .evt_i       (evt_i),
        .evt_info_i  (evt_info_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_line_o  (out_line_o),
        .out_count_o (out_count_o),
        .out_ovf_o   (out_ovf_o),
        .out_info_o  (out_info_o),
`ifdef EVU_ARB_TIMESTAMP_EN
        .out_ts_o    (out_ts_o),
`endif
        .busy_o      (busy_o)
    );

    typedef struct {
        logic [3:0]   evt;
        logic [3:0]   len;
        logic         en;
        logic         rdy;
        logic [17:0]  info;
        logic         exp_valid;
        evu_arb_rec_t exp_rec;   // compared only when exp_valid
        logic         exp_busy;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] evt, input logic [3:0] len,
                                input logic en, input logic rdy,
                                input logic [17:0] info, input logic v,
                                input logic [1:0] line, input logic [7:0] cnt,
                                input logic ovf, input logic [17:0] rinfo,
                                input logic busy);
        vec_t r;
        r.evt = evt; r.len = len; r.en = en; r.rdy = rdy; r.info = info;
        r.exp_valid = v;
        r.exp_rec.line = line; r.exp_rec.count = cnt;
        r.exp_rec.ovf = ovf;   r.exp_rec.info = rinfo;
        r.exp_busy = busy;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        enable_i    = 1'b1;
        line_en_i   = 4'hF;
        evt_i       = 4'h0;
        evt_info_i  = '0;
        out_ready_i = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        evt_i       = 4'h0;
        out_ready_i = 1'b1;
        while (busy_o && cyc < 20) begin
            step();
            cyc++;
        end
        check(name, {63'd0, busy_o}, 64'd0);
    endtask

    vec_t vecs[13];

    initial begin
        // single event, back-pressure accumulate, masked line drain
        vecs[0]  = mk(4'b0100, 4'hF, 1, 1, 18'h12345, 0, 2'd0, 8'd0, 0, 18'h0,     1);
        vecs[1]  = mk(4'b0000, 4'hF, 1, 1, 18'h00000, 1, 2'd2, 8'd1, 0, 18'h12345, 1);
        vecs[2]  = mk(4'b0000, 4'hF, 1, 1, 18'h00000, 0, 2'd0, 8'd0, 0, 18'h0,     0);
        vecs[3]  = mk(4'b0010, 4'hF, 1, 0, 18'h00101, 0, 2'd0, 8'd0, 0, 18'h0,     1);
        vecs[4]  = mk(4'b0010, 4'hF, 1, 0, 18'h00102, 1, 2'd1, 8'd1, 0, 18'h00101, 1);
        vecs[5]  = mk(4'b0010, 4'hF, 1, 0, 18'h00103, 1, 2'd1, 8'd1, 0, 18'h00101, 1);
        vecs[6]  = mk(4'b0010, 4'hF, 1, 0, 18'h00104, 1, 2'd1, 8'd1, 0, 18'h00101, 1);
        vecs[7]  = mk(4'b0010, 4'hF, 1, 0, 18'h00105, 1, 2'd1, 8'd1, 0, 18'h00101, 1);
        vecs[8]  = mk(4'b0000, 4'hF, 1, 1, 18'h00000, 1, 2'd1, 8'd4, 0, 18'h00105, 1);
        vecs[9]  = mk(4'b0000, 4'hF, 1, 1, 18'h00000, 0, 2'd0, 8'd0, 0, 18'h0,     0);
        vecs[10] = mk(4'b1000, 4'hF, 1, 0, 18'h30003, 0, 2'd0, 8'd0, 0, 18'h0,     1);
        vecs[11] = mk(4'b1000, 4'h7, 1, 0, 18'h00BAD, 1, 2'd3, 8'd1, 0, 18'h30003, 1);
        vecs[12] = mk(4'b0000, 4'hF, 1, 1, 18'h00000, 0, 2'd0, 8'd0, 0, 18'h0,     0);

        do_reset();

        // reset state
        check("rst_valid", {63'd0, out_valid_o}, 64'd0);
        check("rst_line",  {62'd0, out_line_o},  64'd0);
        check("rst_count", {56'd0, out_count_o}, 64'd0);
        check("rst_ovf",   {63'd0, out_ovf_o},   64'd0);
        check("rst_info",  {46'd0, out_info_o},  64'd0);
        check("rst_busy",  {63'd0, busy_o},      64'd0);

        // table-driven vectors
        for (int i = 0; i < 13; i++) begin
            evt_i       = vecs[i].evt;
            line_en_i   = vecs[i].len;
            enable_i    = vecs[i].en;
            out_ready_i = vecs[i].rdy;
            evt_info_i  = vecs[i].info;
            step();
            check($sformatf("v%0d_valid", i), {63'd0, out_valid_o}, {63'd0, vecs[i].exp_valid});
            check($sformatf("v%0d_busy", i),  {63'd0, busy_o},      {63'd0, vecs[i].exp_busy});
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_line", i),  {62'd0, out_line_o},  {62'd0, vecs[i].exp_rec.line});
                check($sformatf("v%0d_count", i), {56'd0, out_count_o}, {56'd0, vecs[i].exp_rec.count});
                check($sformatf("v%0d_ovf", i),   {63'd0, out_ovf_o},   {63'd0, vecs[i].exp_rec.ovf});
                check($sformatf("v%0d_info", i),  {46'd0, out_info_o},  {46'd0, vecs[i].exp_rec.info});
            end
        end
        idle_inputs();

        // saturation: held record, then 300 events on line 0
        do_reset();
        out_ready_i = 1'b0;
        evt_i = 4'b0001; evt_info_i = 18'h00001;
        step();
        evt_i = 4'b0000;
        step();
        check("sat_first_count", {56'd0, out_count_o}, 64'd1);
        evt_i = 4'b0001; evt_info_i = 18'h0AAAA;
        for (int i = 0; i < 300; i++) step();
        check("sat_held_valid", {63'd0, out_valid_o}, 64'd1);
        check("sat_held_count", {56'd0, out_count_o}, 64'd1);
        evt_i = 4'b0000; out_ready_i = 1'b1;
        step();
        check("sat_valid", {63'd0, out_valid_o}, 64'd1);
        check("sat_count", {56'd0, out_count_o}, 64'd255);
        check("sat_ovf",   {63'd0, out_ovf_o},   64'd1);
        check("sat_info",  {46'd0, out_info_o},  64'h0AAAA);
        out_ready_i = 1'b0; evt_i = 4'b0001; evt_info_i = 18'h0BBBB;
        step();
        evt_i = 4'b0000; out_ready_i = 1'b1;
        step();
        check("post_sat_count", {56'd0, out_count_o}, 64'd1);
        check("post_sat_ovf",   {63'd0, out_ovf_o},   64'd0);
        check("post_sat_info",  {46'd0, out_info_o},  64'h0BBBB);
        drain("sat_drain_busy");

        // fairness: every line pulses every cycle, ready stuck high
        do_reset();
        evt_i = 4'hF; evt_info_i = 18'h00F0F;
        step();
        for (int r = 0; r < 12; r++) begin
            step();
            check($sformatf("fair%0d_valid", r), {63'd0, out_valid_o}, 64'd1);
            check($sformatf("fair%0d_line", r),  {62'd0, out_line_o},  64'(r % 4));
            check($sformatf("fair%0d_count", r), {56'd0, out_count_o}, 64'((r < 3) ? r + 1 : 4));
        end
        drain("fair_drain_busy");

        // flush: three lines pending, held record, enable low one cycle
        do_reset();
        out_ready_i = 1'b0;
        evt_i = 4'b0111; evt_info_i = 18'h00777;
        step();
        evt_i = 4'b0000;
        step();
        check("flush_held_line", {62'd0, out_line_o}, 64'd0);
        enable_i = 1'b0;
        step();
        check("flush_held_valid", {63'd0, out_valid_o}, 64'd1);
        enable_i = 1'b1; out_ready_i = 1'b1;
        step();
        check("flush_done_valid", {63'd0, out_valid_o}, 64'd0);
        check("flush_done_busy",  {63'd0, busy_o},      64'd0);
        repeat (3) step();
        check("flush_quiet_valid", {63'd0, out_valid_o}, 64'd0);
        check("flush_quiet_busy",  {63'd0, busy_o},      64'd0);

`ifdef EVU_ARB_TIMESTAMP_EN
        // capture on the 11th edge after reset release samples timestamp 10
        do_reset();
        repeat (9) step();
        evt_i = 4'b0001;
        step();
        evt_i = 4'b0000;
        step();
        check("ts_valid", {63'd0, out_valid_o}, 64'd1);
        check("ts_value", {32'd0, out_ts_o},    64'd10);
        drain("ts_drain_busy");
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
